// File: rtl/src_main_memory.sv
// -----------------------------------------------------------------------------
// src_main_memory
//
// Word-organised main memory for the SRC datapath, sitting directly behind the
// memory controller. Each access takes WAIT_CYCLES wait states. Completion is
// signalled by a one-cycle done pulse.
//
// Request/response handshake:
//   The controller raises enable with address/read (and write data on
//   mem_bus). The request is accepted on the first rising edge where the block
//   is IDLE and enable=1. Once accepted, the request always completes, even if
//   enable drops. done pulses for exactly one cycle. If enable is still high
//   after that cycle, the block parks in HOLD and keeps driving read data until
//   enable falls. A fresh request needs enable low for at least one edge.
//
// Parameters:
//   MEM_WORDS   - number of 32-bit words implemented (2..16384)
//   WAIT_CYCLES - wait states between acceptance and completion (0..15)
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   address   - byte address; the word index is address[15:2]
//   read      - 1 = read, 0 = write (qualified by enable)
//   enable    - access request
//   mem_bus   - shared tristate data bus: driven with read data in DONE/HOLD,
//               sampled as write data on acceptance
//   done      - one-cycle completion pulse
//   busy      - high whenever the FSM is not IDLE
//   err       - out-of-range flag, valid only while done is high
//   fsm_state - current FSM state (0 IDLE, 1 WAIT, 2 DONE, 3 HOLD)
// -----------------------------------------------------------------------------
module src_main_memory #(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] address,
   input  logic        read,
   input  logic        enable,
   inout  wire  [31:0] mem_bus,
   output logic        done,
   output logic        busy,
   output logic        err,
   output logic [1:0]  fsm_state
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD   = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [14:0]   WORD_LIMIT = 15'(MEM_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt_q;
   logic [13:0]   idx_q;
   logic          read_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic [31:0]   mem [MEM_WORDS];

   logic          accept;
   logic          done_entry;
   logic [13:0]   req_idx;
   logic          req_read;
   logic [31:0]   req_wdata;
   logic          in_range;
   logic          mem_we;

   assign accept     = (state == S_IDLE) && enable;
   assign done_entry = (state_next == S_DONE);

   // With zero wait states DONE is entered on the acceptance edge itself, so
   // the request fields come straight from the inputs. Otherwise they come
   // from the latched copies.
   assign req_idx   = (state == S_IDLE) ? address[15:2] : idx_q;
   assign req_read  = (state == S_IDLE) ? read          : read_q;
   assign req_wdata = (state == S_IDLE) ? mem_bus       : wdata_q;
   assign in_range  = ({1'b0, req_idx} < WORD_LIMIT);

   // rst_n gating keeps a reset asserted alongside enable from writing the array.
   assign mem_we = rst_n && done_entry && !req_read && in_range;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and status outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      done       = 1'b0;
      busy       = 1'b1;
      err        = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (enable) begin
               state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            err        = err_q;
            state_next = enable ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (!enable) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign fsm_state = state;

   // ---------------------------------------------------------------------------
   // Wait-state counter: loaded on acceptance, counts down through WAIT.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= CNT_LOAD;
      end else if ((state == S_WAIT) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Request latch and completion registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         read_q  <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            idx_q  <= address[15:2];
            read_q <= read;
            if (!read) begin
               wdata_q <= mem_bus;
            end
         end
         if (done_entry) begin
            err_q <= !in_range;
            if (req_read) begin
               rdata_q <= in_range ? mem[req_idx[AW-1:0]] : 32'h0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Storage array. It is not reset: contents survive rst_n.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[req_idx[AW-1:0]] <= req_wdata;
      end
   end

   // Read data stays on the bus through DONE and HOLD, so the controller can
   // capture it while it keeps enable && read asserted.
   assign mem_bus = (((state == S_DONE) || (state == S_HOLD)) && read_q) ? rdata_q : 32'bz;

endmodule
